framebuffer_row_dump: RTL
=========================

Name: framebuffer_row_dump

Overview:
- Reads one 64-pixel row back out of the framebuffer RAM port A (8-bit data, 12-bit byte address) and transmits it over an 8N1 UART.
- Uses exactly the framing control_module accepts on uart_rx: 'L', row byte, then 128 pixel bytes. Dumped lines can therefore be replayed into the display unchanged.
- Sits beside control_module on clk_root. Triggered by a debugger command; its tx output is muxed onto a spare pin.

Parameters:
- DIVIDER_TICKS, 20'd1000000: clk_in cycles per UART bit.
- DIVIDER_TICKS_WIDTH, 20: width of the baud counter.
- ROW_BYTES, 128: pixel bytes per row (64 px x 2 bytes RGB565).
- ROW_ADDR_WIDTH, 5: row index width (32 rows).

Ports:
- clk_in, input, 1: system clock (clk_root).
- reset, input, 1: synchronous, active-high.
- start, input, 1: one-cycle request pulse. Sampled only in IDLE.
- row, input, ROW_ADDR_WIDTH: row to dump. Latched on an accepted start.
- busy, output, 1: high from the cycle after an accepted start until done.
- done, output, 1: one-cycle pulse after the final stop bit.
- ram_address, output, 12: byte address = {row_latched, byte_idx[6:0]}.
- ram_clk_enable, output, 1: read strobe.
- ram_data_in, input, 8: RAM read data, valid 1 cycle after ram_clk_enable.
- tx_out, output, 1: UART serial output. Idle high.

Behaviour:
- Reset values: busy=0, done=0, ram_clk_enable=0, ram_address=0, tx_out=1, FSM=IDLE, all counters 0.
- Reset in any state aborts within the same edge. tx_out returns high immediately, and no partial byte is completed.
- Main FSM:
  - IDLE: on start, latch row, byte_idx=0, busy=1, go to SEND_L.
  - SEND_L: load 8'h4C ('L') into the tx sub-module, go to WAIT_TX, then SEND_ROW.
  - SEND_ROW: load {3'b0,row_latched}, go to WAIT_TX, then FETCH.
  - FETCH: ram_clk_enable=1 for exactly one cycle with ram_address for byte_idx, go to CAPTURE.
  - CAPTURE: register ram_data_in, load it into tx, go to WAIT_TX.
  - WAIT_TX: wait for tx_ready. Afterwards, if byte_idx==ROW_BYTES-1 go to DONE; otherwise byte_idx+1 and go to FETCH.
  - DONE: done=1 for one cycle, busy=0, go to IDLE.
- start while busy is ignored, not queued. start and reset in the same cycle: reset wins.
- byte_idx is 7 bits. Its last value is 127; no wrap into the next row's addresses.
- Exactly 130 bytes per dump. Bytes go out in ascending address order.
- Bit timing:
  - Each bit lasts exactly DIVIDER_TICKS cycles. The frame is start(0), d0..d7 LSB first, stop(1).
  - Inter-byte gap is at most 3 cycles of idle-high beyond the stop bit (FETCH/CAPTURE overhead).
  - tx_ready rises the cycle after the stop bit's last tick.
- The RAM port is read-only. No write-enable is driven; the integrator ties PortAWriteEnable to control_module.

Decomposition:
- Shared package: state encoding localparams (IDLE, SEND_L, SEND_ROW, FETCH, CAPTURE, WAIT_TX, DONE), CMD_LINE = 8'h4C, ROW_BYTES.
- Sub-module uart_tx_byte (clk_in, reset, load, data[7:0], tx_out, tx_ready). It holds the baud counter and 10-bit shift register. It is reusable by debugger.

Test Plan:
- Reset, then 50 idle cycles -> tx_out=1, busy=0, ram_clk_enable=0 throughout.
- DIVIDER_TICKS=4, RAM preloaded with byte = address[7:0], start with row=5 -> UART decoder sees 8'h4C, 8'h05, then 8'h80..8'hFF (addresses 0x280-0x2FF). done pulses once; busy falls the same cycle.
- Same setup with row=31 -> last address read is 12'hFFF. No access above 12'hFFF, no wrap to 0.
- start pulsed again mid-dump with row=2 -> ignored. Output is identical to a single row=5 dump, and exactly 130 bytes are sent.
- reset asserted during the 40th data byte's bit 3 -> the next cycle shows tx_out=1, busy=0, FSM in IDLE. A following start with row=0 produces a clean full dump.
- Bit-timing check, DIVIDER_TICKS=7 -> every bit is held exactly 7 cycles, and the per-byte period is at most 70+3 cycles.

Source files
------------

// File: rtl/framebuffer_row_dump_pkg.sv
// Shared definitions for the framebuffer row dumper: FSM state encoding,
// the kind of byte currently in flight on the UART, and framing constants.
// The command byte matches what control_module expects at the start of a line.
package framebuffer_row_dump_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SEND_L   = 3'd1,
    SEND_ROW = 3'd2,
    FETCH    = 3'd3,
    CAPTURE  = 3'd4,
    WAIT_TX  = 3'd5,
    DONE     = 3'd6
  } state_e;

  // Which byte of the line is currently being shifted out.
  // WAIT_TX uses this to decide where to go next.
  typedef enum logic [1:0] {
    KIND_CMD = 2'd0,
    KIND_ROW = 2'd1,
    KIND_PIX = 2'd2
  } kind_e;

  localparam logic [7:0]  CMD_LINE       = 8'h4C;  // ASCII 'L'
  localparam int unsigned ROW_BYTES      = 128;    // 64 px x RGB565
  localparam int unsigned BYTE_IDX_WIDTH = 7;

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 UART transmitter for one byte at a time; reusable standalone.
// Latency: start bit appears the cycle after load; each bit lasts DIVIDER_TICKS cycles.
// Backpressure: load is ignored while a frame is in flight; tx_ready rises the cycle after the stop bit's last tick.
// Ports: clk_in/reset (sync, active-high), load + data[7:0] request a frame,
//        tx_out serial line (idle high), tx_ready high when a new byte can be loaded.
module uart_tx_byte #(
  parameter int unsigned DIVIDER_TICKS       = 1000000,
  parameter int unsigned DIVIDER_TICKS_WIDTH = 20
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] data,
  output logic       tx_out,
  output logic       tx_ready
);

  logic [DIVIDER_TICKS_WIDTH-1:0] baud_q, baud_d;
  logic [3:0]                     bit_q, bit_d;
  logic [9:0]                     shift_q, shift_d;
  logic                           active_q, active_d;
  logic                           tick;

  assign tick = (baud_q == DIVIDER_TICKS_WIDTH'(DIVIDER_TICKS - 1));

  always_comb begin
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    active_d = active_q;
    if (!active_q) begin
      if (load) begin
        active_d = 1'b1;
        baud_d   = '0;
        bit_d    = '0;
        shift_d  = {1'b1, data, 1'b0};  // stop, d7..d0, start (LSB goes first)
      end
    end else if (tick) begin
      baud_d  = '0;
      // Ones are shifted in behind the frame, so the line rests high once
      // the stop bit has been consumed.
      shift_d = {1'b1, shift_q[9:1]};
      if (bit_q == 4'd9) begin
        active_d = 1'b0;
      end else begin
        bit_d = bit_q + 4'd1;
      end
    end else begin
      baud_d = baud_q + 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '1;
      active_q <= 1'b0;
    end else begin
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      active_q <= active_d;
    end
  end

  assign tx_out   = shift_q[0];
  assign tx_ready = ~active_q;

endmodule

// File: rtl/framebuffer_row_dump.sv
// Dumps one framebuffer row over UART as 'L', row, 128 pixel bytes (replayable into control_module).
// Latency: busy the cycle after an accepted start; done pulses two cycles after the final stop bit ends.
// Backpressure: start is only honoured in IDLE; requests while busy are dropped, not queued.
// Ports: clk_in/reset (sync, active-high); start/row request a dump; busy/done status;
//        ram_address/ram_clk_enable/ram_data_in read-only RAM port A (1-cycle read); tx_out serial line.
module framebuffer_row_dump
  import framebuffer_row_dump_pkg::*;
#(
  parameter int unsigned DIVIDER_TICKS       = 1000000,
  parameter int unsigned DIVIDER_TICKS_WIDTH = 20,
  parameter int unsigned ROW_BYTES           = 128,
  parameter int unsigned ROW_ADDR_WIDTH      = 5
) (
  input  logic                      clk_in,
  input  logic                      reset,
  input  logic                      start,
  input  logic [ROW_ADDR_WIDTH-1:0] row,
  output logic                      busy,
  output logic                      done,
  output logic [11:0]               ram_address,
  output logic                      ram_clk_enable,
  input  logic [7:0]                ram_data_in,
  output logic                      tx_out
);

  state_e                      state_q, state_d;
  kind_e                       kind_q, kind_d;
  logic [ROW_ADDR_WIDTH-1:0]   row_q, row_d;
  logic [BYTE_IDX_WIDTH-1:0]   idx_q, idx_d;
  logic                        tx_load;
  logic [7:0]                  tx_data;
  logic                        tx_ready;

  always_comb begin
    state_d        = state_q;
    kind_d         = kind_q;
    row_d          = row_q;
    idx_d          = idx_q;
    tx_load        = 1'b0;
    tx_data        = 8'h00;
    ram_clk_enable = 1'b0;
    done           = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          row_d   = row;
          idx_d   = '0;
          state_d = SEND_L;
        end
      end
      SEND_L: begin
        tx_load = 1'b1;
        tx_data = CMD_LINE;
        kind_d  = KIND_CMD;
        state_d = WAIT_TX;
      end
      SEND_ROW: begin
        tx_load = 1'b1;
        tx_data = 8'(row_q);
        kind_d  = KIND_ROW;
        state_d = WAIT_TX;
      end
      FETCH: begin
        ram_clk_enable = 1'b1;
        state_d        = CAPTURE;
      end
      CAPTURE: begin
        // RAM data is valid this cycle; the transmitter's shift register
        // is the capture register.
        tx_load = 1'b1;
        tx_data = ram_data_in;
        kind_d  = KIND_PIX;
        state_d = WAIT_TX;
      end
      WAIT_TX: begin
        if (tx_ready) begin
          unique case (kind_q)
            KIND_CMD: state_d = SEND_ROW;
            KIND_ROW: state_d = FETCH;
            KIND_PIX: begin
              // Stop at the row's last byte so the index never wraps into
              // the next row's addresses.
              if (idx_q == BYTE_IDX_WIDTH'(ROW_BYTES - 1)) begin
                state_d = DONE;
              end else begin
                idx_d   = idx_q + 1'b1;
                state_d = FETCH;
              end
            end
            default: state_d = IDLE;
          endcase
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q <= IDLE;
      kind_q  <= KIND_CMD;
      row_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      row_q   <= row_d;
      idx_q   <= idx_d;
    end
  end

  // busy drops in DONE so that it falls in the same cycle done pulses.
  assign busy        = (state_q != IDLE) && (state_q != DONE);
  assign ram_address = 12'({row_q, idx_q});

  uart_tx_byte #(
    .DIVIDER_TICKS      (DIVIDER_TICKS),
    .DIVIDER_TICKS_WIDTH(DIVIDER_TICKS_WIDTH)
  ) u_tx (
    .clk_in  (clk_in),
    .reset   (reset),
    .load    (tx_load),
    .data    (tx_data),
    .tx_out  (tx_out),
    .tx_ready(tx_ready)
  );

endmodule
